// File: rtl/sdram_page_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sdram_page_sequencer
// Description : Page-level command source for sdram_fifo_interface. Turns
//               display line requests into full-page (512-word) reads and
//               write-FIFO fill level into page writes. A pending display read
//               always has priority over a pending write.
//               Optional macro SEQ_STATS_EN adds saturating page/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_page_sequencer #(
    parameter int          PAGES_PER_LINE = 2,
    parameter int          LINES          = 480,
    parameter logic [12:0] BASE_ROW       = 13'd0
) (
    input  logic        sram_clk,
    input  logic        rst_n,
    input  logic        rd_line_req,
    input  logic [9:0]  rd_line,
    input  logic [10:0] rfifo_space,
    input  logic [10:0] wfifo_level,
    input  logic        in_idle,
    input  logic        r_fifo,
    input  logic        w_fifo,
    output logic [2:0]  user_cmd,
    output logic [14:0] f_addr,
    output logic        wfifo_rd_en,
    output logic        rfifo_wr_en,
    output logic        busy,
    output logic        rd_overrun
`ifdef SEQ_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_rd_pages,
    output logic [31:0] stat_wr_pages,
    output logic [31:0] stat_stall
`endif
);

    localparam int          c_PAGES      = LINES * PAGES_PER_LINE;
    localparam int          c_PW         = (c_PAGES > 3) ? $clog2(c_PAGES + 1) : 2;
    localparam int          c_KW         = $clog2(PAGES_PER_LINE + 1);
    localparam logic [10:0] c_PAGE_WORDS = 11'd512;
    localparam logic [2:0]  c_CMD_IDLE   = 3'd0;
    localparam logic [2:0]  c_CMD_READ   = 3'd1;
    localparam logic [2:0]  c_CMD_WRITE  = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_R = 3'd1,
        S_ISSUE_W = 3'd2,
        S_BUSY_R  = 3'd3,
        S_BUSY_W  = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [9:0]        r_line;
    logic [c_KW-1:0]   r_k;
    logic              r_rd_pend;
    logic              r_stale;
    logic              r_rd_overrun;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [14:0]       r_f_addr;

    logic              w_go_rd;
    logic              w_go_wr;
    logic              w_launch_rd;
    logic              w_launch_wr;
    logic              w_done_rd;
    logic              w_done_wr;
    logic [c_PW-1:0]   w_rd_page;
    logic [c_PW-1:0]   w_sel_page;
    logic [c_KW-1:0]   w_k_inc;

    // Decisions use only registered read state, so a request is seen one cycle late
    assign w_go_rd     = r_rd_pend && (rfifo_space >= c_PAGE_WORDS);
    assign w_go_wr     = (wfifo_level >= c_PAGE_WORDS);
    assign w_launch_rd = (r_state == S_IDLE) && in_idle && w_go_rd;
    assign w_launch_wr = (r_state == S_IDLE) && in_idle && !w_go_rd && w_go_wr;
    assign w_done_rd   = (r_state == S_BUSY_R) && in_idle;
    assign w_done_wr   = (r_state == S_BUSY_W) && in_idle;
    assign w_rd_page   = c_PW'(int'(r_line) * PAGES_PER_LINE + int'(r_k));
    assign w_sel_page  = w_launch_rd ? w_rd_page : r_wr_ptr;
    assign w_k_inc     = r_k + c_KW'(1);

    assign f_addr      = r_f_addr;
    assign busy        = (r_state != S_IDLE);
    assign rd_overrun  = r_rd_overrun;
    assign wfifo_rd_en = r_fifo && (r_state == S_BUSY_W);
    assign rfifo_wr_en = w_fifo && (r_state == S_BUSY_R);

    // State register
    always_ff @(posedge sram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and command decode; the command drops as soon as in_idle acknowledges
    always_comb begin
        w_state_nxt = r_state;
        user_cmd    = c_CMD_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_launch_rd) begin
                    w_state_nxt = S_ISSUE_R;
                end else if (w_launch_wr) begin
                    w_state_nxt = S_ISSUE_W;
                end
            end
            S_ISSUE_R: begin
                user_cmd = c_CMD_READ;
                if (!in_idle) begin
                    w_state_nxt = S_BUSY_R;
                end
            end
            S_ISSUE_W: begin
                user_cmd = c_CMD_WRITE;
                if (!in_idle) begin
                    w_state_nxt = S_BUSY_W;
                end
            end
            S_BUSY_R: begin
                if (in_idle) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_BUSY_W: begin
                if (in_idle) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Page address latched at issue and held through the burst and gap
    always_ff @(posedge sram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_addr <= 15'd0;
        end else if (w_launch_rd || w_launch_wr) begin
            r_f_addr <= {BASE_ROW + 13'(w_sel_page >> 2), w_sel_page[1:0]};
        end
    end

    // Line tracking: a new request restarts the line; a page issued for a replaced line does not advance k
    always_ff @(posedge sram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line       <= 10'd0;
            r_k          <= '0;
            r_rd_pend    <= 1'b0;
            r_stale      <= 1'b0;
            r_rd_overrun <= 1'b0;
        end else begin
            if (w_launch_rd) begin
                r_stale <= rd_line_req;
            end else if (rd_line_req && ((r_state == S_ISSUE_R) || (r_state == S_BUSY_R))) begin
                r_stale <= 1'b1;
            end

            if (rd_line_req) begin
                r_line    <= rd_line;
                r_k       <= '0;
                r_rd_pend <= 1'b1;
                if (r_rd_pend) begin
                    r_rd_overrun <= 1'b1;
                end
            end else if (w_done_rd && !r_stale) begin
                if (w_k_inc == c_KW'(PAGES_PER_LINE)) begin
                    r_k       <= '0;
                    r_rd_pend <= 1'b0;
                end else begin
                    r_k <= w_k_inc;
                end
            end
        end
    end

    // Write page pointer advances per completed write and wraps at the frame end
    always_ff @(posedge sram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_done_wr) begin
            if (r_wr_ptr == c_PW'(c_PAGES - 1)) begin
                r_wr_ptr <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
        end
    end

`ifdef SEQ_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;
    logic [31:0] r_stat_stall;

    assign stat_rd_pages = r_stat_rd;
    assign stat_wr_pages = r_stat_wr;
    assign stat_stall    = r_stat_stall;

    // Saturating statistics counters with synchronous clear pulse
    always_ff @(posedge sram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_rd    <= 32'd0;
            r_stat_wr    <= 32'd0;
            r_stat_stall <= 32'd0;
        end else if (stat_clr) begin
            r_stat_rd    <= 32'd0;
            r_stat_wr    <= 32'd0;
            r_stat_stall <= 32'd0;
        end else begin
            if (w_done_rd && (r_stat_rd != '1)) begin
                r_stat_rd <= r_stat_rd + 32'd1;
            end
            if (w_done_wr && (r_stat_wr != '1)) begin
                r_stat_wr <= r_stat_wr + 32'd1;
            end
            if (r_rd_pend && (rfifo_space < c_PAGE_WORDS) && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_page_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_page_sequencer
// Description : Self-checking bench for sdram_page_sequencer with a
//               behavioural sdram_fifo_interface stub (3-cycle setup,
//               512-cycle burst) and a transaction-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_page_sequencer;

    localparam int c_PPL   = 2;
    localparam int c_LINES = 4;
    localparam int c_NP    = c_PPL * c_LINES;

    logic        sram_clk    = 1'b0;
    logic        rst_n       = 1'b0;
    logic        rd_line_req = 1'b0;
    logic [9:0]  rd_line     = 10'd0;
    logic [10:0] rfifo_space = 11'd0;
    logic [10:0] wfifo_level = 11'd0;
    logic        in_idle;
    logic        r_fifo;
    logic        w_fifo;
    logic [2:0]  user_cmd;
    logic [14:0] f_addr;
    logic        wfifo_rd_en;
    logic        rfifo_wr_en;
    logic        busy;
    logic        rd_overrun;
`ifdef SEQ_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_rd_pages;
    logic [31:0] stat_wr_pages;
    logic [31:0] stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    // model state
    int          m_line = 0, m_next_k = 0, m_left = 0, m_gen = 0, m_inflight_gen = -1, m_wp = 0;
    bit          m_overrun = 1'b0;
    int          cur_cmd = 0, prev_cmd = 0;
    logic        prev_idle = 1'b1;
    logic [14:0] cur_addr = 15'd0, mon_exp = 15'd0;
    int          rd_pulses = 0, wr_pulses = 0, launches = 0;

    // stub state
    int stub_phase = 0, stub_cnt = 0, stub_cmd = 0;

    sdram_page_sequencer #(
        .PAGES_PER_LINE (c_PPL),
        .LINES          (c_LINES),
        .BASE_ROW       (13'd0)
    ) dut (
        .sram_clk    (sram_clk),
        .rst_n       (rst_n),
        .rd_line_req (rd_line_req),
        .rd_line     (rd_line),
        .rfifo_space (rfifo_space),
        .wfifo_level (wfifo_level),
        .in_idle     (in_idle),
        .r_fifo      (r_fifo),
        .w_fifo      (w_fifo),
        .user_cmd    (user_cmd),
        .f_addr      (f_addr),
        .wfifo_rd_en (wfifo_rd_en),
        .rfifo_wr_en (rfifo_wr_en),
        .busy        (busy),
        .rd_overrun  (rd_overrun)
`ifdef SEQ_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_rd_pages (stat_rd_pages),
        .stat_wr_pages (stat_wr_pages),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 sram_clk = ~sram_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] page_addr(input int p);
        logic [12:0] row;
        logic [1:0]  bank;
        row  = 13'(p / 4);
        bank = 2'(p % 4);
        return {row, bank};
    endfunction

    // Downstream stub: acknowledges a command by dropping in_idle, then setup and burst
    initial begin
        in_idle = 1'b1;
        r_fifo  = 1'b0;
        w_fifo  = 1'b0;
        forever begin
            @(negedge sram_clk);
            if (!rst_n) begin
                in_idle    = 1'b1;
                r_fifo     = 1'b0;
                w_fifo     = 1'b0;
                stub_phase = 0;
            end else begin
                case (stub_phase)
                    0: if (user_cmd != 3'd0) begin
                        stub_cmd   = int'(user_cmd);
                        in_idle    = 1'b0;
                        stub_cnt   = 0;
                        stub_phase = 1;
                    end
                    1: begin
                        stub_cnt++;
                        if (stub_cnt == 3) begin
                            stub_phase = 2;
                            stub_cnt   = 0;
                            if (stub_cmd == 1) w_fifo = 1'b1;
                            else               r_fifo = 1'b1;
                        end
                    end
                    default: begin
                        stub_cnt++;
                        if (stub_cnt == 512) begin
                            w_fifo     = 1'b0;
                            r_fifo     = 1'b0;
                            in_idle    = 1'b1;
                            stub_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Compare process: checks every cycle against the page-level model
    initial begin
        forever begin
            @(posedge sram_clk);
            #1;
            if (!rst_n) begin
                m_left    = 0;
                m_next_k  = 0;
                m_wp      = 0;
                m_overrun = 1'b0;
                m_gen++;
                cur_cmd   = 0;
                cur_addr  = 15'd0;
                prev_cmd  = 0;
                prev_idle = 1'b1;
            end else begin
                if (user_cmd != 3'd0 && prev_cmd == 0) begin
                    launches++;
                    if (user_cmd == 3'd1) begin
                        chk("read_launch_allowed", 32'(m_left > 0 && m_next_k < c_PPL), 32'd1);
                        mon_exp = page_addr(m_line * c_PPL + m_next_k);
                        m_next_k++;
                        m_inflight_gen = m_gen;
                    end else begin
                        mon_exp = page_addr(m_wp);
                        m_wp    = (m_wp + 1) % c_NP;
                    end
                    chk("launch_addr", 32'(f_addr), 32'(mon_exp));
                    cur_cmd  = int'(user_cmd);
                    cur_addr = mon_exp;
                end
                if (busy && cur_cmd != 0) chk("f_addr_stable", 32'(f_addr), 32'(cur_addr));
                chk("rfifo_wr_en", 32'(rfifo_wr_en), 32'(w_fifo && cur_cmd == 1));
                chk("wfifo_rd_en", 32'(wfifo_rd_en), 32'(r_fifo && cur_cmd == 2));
                if (!in_idle) begin
                    chk("busy_while_downstream_active", 32'(busy), 32'd1);
                    chk("no_cmd_while_not_idle", 32'(user_cmd), 32'd0);
                end
                chk("rd_overrun", 32'(rd_overrun), 32'(m_overrun));
                rd_pulses += int'(rfifo_wr_en);
                wr_pulses += int'(wfifo_rd_en);
                if (in_idle && !prev_idle && cur_cmd == 1 && m_inflight_gen == m_gen && m_left > 0)
                    m_left--;
                prev_cmd  = int'(user_cmd);
                prev_idle = in_idle;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sram_clk);
        #1;
    endtask

    task automatic req_line(input int l);
        @(negedge sram_clk);
        #1;
        rd_line_req = 1'b1;
        rd_line     = 10'(l);
        if (m_left > 0) m_overrun = 1'b1;
        m_line   = l;
        m_next_k = 0;
        m_left   = c_PPL;
        m_gen++;
        @(negedge sram_clk);
        #1;
        rd_line_req = 1'b0;
    endtask

    task automatic wait_cmd(input string name, output int cmd, output logic [14:0] addr);
        bit found;
        found = 1'b0;
        cmd   = 0;
        addr  = 15'd0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge sram_clk);
            #1;
            if (user_cmd != 3'd0) begin
                found = 1'b1;
                cmd   = int'(user_cmd);
                addr  = f_addr;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: no command within 1500 cycles, got none expected one", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 4; i++) begin
            @(negedge sram_clk);
            #1;
            if (!busy && in_idle) quiet++;
            else                  quiet = 0;
        end
        if (quiet < 4) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still %0d after 3000 cycles, expected 0", name, busy);
        end
    endtask

    task automatic expect_cmd(input string name, input int exp_cmd, input logic [14:0] exp_addr);
        int          c;
        logic [14:0] a;
        wait_cmd(name, c, a);
        chk({name, "_cmd"}, 32'(c), 32'(exp_cmd));
        chk({name, "_addr"}, 32'(a), 32'(exp_addr));
    endtask

    initial begin
        int   base;
        bit   seen;
        // reset state
        tick(3);
        chk("reset_user_cmd", 32'(user_cmd), 32'd0);
        chk("reset_f_addr", 32'(f_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_overrun", 32'(rd_overrun), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // 1: line 3 -> pages 6 and 7, 1024 read pushes
        base        = rd_pulses;
        rfifo_space = 11'd1024;
        req_line(3);
        expect_cmd("t1_page6", 1, {13'd1, 2'd2});
        expect_cmd("t1_page7", 1, {13'd1, 2'd3});
        wait_idle("t1_idle");
        chk("t1_rd_pulses", 32'(rd_pulses - base), 32'd1024);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // 2: write-FIFO level drives writes from page 0 upward
        base        = wr_pulses;
        wfifo_level = 11'd600;
        expect_cmd("t2_write0", 2, 15'd0);
        wfifo_level = 11'd0;
        wait_idle("t2_idle_a");
        chk("t2_wr_pulses", 32'(wr_pulses - base), 32'd512);
        wfifo_level = 11'd600;
        expect_cmd("t2_write1", 2, {13'd0, 2'd1});
        wfifo_level = 11'd0;
        wait_idle("t2_idle_b");

        // 3: read and write eligible in the same cycle -> both read pages, then write page 2
        rfifo_space = 11'd100;
        req_line(0);
        tick(3);
        rfifo_space = 11'd1024;
        wfifo_level = 11'd600;
        expect_cmd("t3_read_first", 1, {13'd0, 2'd0});
        expect_cmd("t3_read_second", 1, {13'd0, 2'd1});
        expect_cmd("t3_write_after", 2, {13'd0, 2'd2});
        wfifo_level = 11'd0;
        wait_idle("t3_idle");

        // 4: insufficient read space stalls the read; raising it issues within 2 cycles
        rfifo_space = 11'd100;
        req_line(1);
        base = launches;
        tick(20);
        chk("t4_stalled", 32'(launches - base), 32'd0);
        rfifo_space = 11'd512;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge sram_clk);
            #1;
            if (user_cmd != 3'd0) begin
                seen = 1'b1;
                chk("t4_cmd", 32'(user_cmd), 32'd1);
                chk("t4_addr", 32'(f_addr), 32'({13'd0, 2'd2}));
            end
        end
        chk("t4_within_2_cycles", 32'(seen), 32'd1);
        expect_cmd("t4_page3", 1, {13'd0, 2'd3});
        wait_idle("t4_idle");

        // 5: second request mid-burst -> overrun; in-flight page completes, new line from k=0
        base        = rd_pulses;
        rfifo_space = 11'd1024;
        req_line(2);
        expect_cmd("t5_page4", 1, {13'd1, 2'd0});
        tick(100);
        chk("t5_overrun_before", 32'(rd_overrun), 32'd0);
        req_line(0);
        chk("t5_overrun_after", 32'(rd_overrun), 32'd1);
        expect_cmd("t5_new_line_k0", 1, {13'd0, 2'd0});
        expect_cmd("t5_new_line_k1", 1, {13'd0, 2'd1});
        wait_idle("t5_idle");
        chk("t5_rd_pulses", 32'(rd_pulses - base), 32'd1536);

        // 6: write pointer runs 3..7 then wraps to 0; reset mid-burst
        wfifo_level = 11'd600;
        for (int i = 0; i < 6; i++) begin
            expect_cmd("t6_write", 2, page_addr((3 + i) % c_NP));
        end
        tick(200);
        chk("t6_midburst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_reset_user_cmd", 32'(user_cmd), 32'd0);
        chk("t6_reset_busy", 32'(busy), 32'd0);
        chk("t6_reset_overrun", 32'(rd_overrun), 32'd0);
        tick(3);
        rst_n = 1'b1;
        expect_cmd("t6_after_reset", 2, 15'd0);
        wfifo_level = 11'd0;
        wait_idle("t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
